util_axis_puf_multi_controller: RTL

//  AXI-Stream command front-end for a bank of PUF_CHANNELS PUF cores sharing one challenge bus.

---
 rtl/util_axis_puf_pkg.sv | 21 ++
 rtl/util_axis_puf_chan_mux.sv | 25 ++
 rtl/util_axis_puf_multi_controller.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/util_axis_puf_pkg.sv
// Shared opcodes, status codes and FSM state encoding for the AXI-Stream PUF controller.
package util_axis_puf_pkg;

  localparam logic [3:0] OP_SET_A = 4'h1;
  localparam logic [3:0] OP_SET_B = 4'h2;
  localparam logic [3:0] OP_RUN   = 4'h4;
  localparam logic [3:0] OP_STAT  = 4'h8;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_BADCH   = 2'b10;
  localparam logic [1:0] ST_STAT    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/util_axis_puf_chan_mux.sv
// Selects one PUF channel's response word and valid bit by the latched channel index.
module util_axis_puf_chan_mux #(
  parameter int DATA_WIDTH   = 8,
  parameter int PUF_CHANNELS = 2
) (
  input  logic [DATA_WIDTH-1:0]              ch,
  input  logic [PUF_CHANNELS*DATA_WIDTH-1:0] puf_data,
  input  logic [PUF_CHANNELS-1:0]            puf_valid,
  output logic [DATA_WIDTH-1:0]              sel_data,
  output logic                               sel_valid
);

  // Out-of-range indices select nothing, so a stray index can never complete a wait.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int c = 0; c < PUF_CHANNELS; c++) begin
      if (ch == DATA_WIDTH'(c)) begin
        sel_data  = puf_data[c*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = puf_valid[c];
      end
    end
  end

endmodule

// File: rtl/util_axis_puf_multi_controller.sv
// AXI-Stream command front-end for a bank of PUF cores sharing one challenge bus.
// Define PUF_TIMEOUT_EN to build the WAIT-state timeout counter (status 01).
module util_axis_puf_multi_controller
  import util_axis_puf_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int SEL_WIDTH      = 8,
  parameter int PUF_CHANNELS   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               aclk,
  input  logic                               arst,
  input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
  input  logic [3:0]                         s_axis_tuser,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  output logic [DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [1:0]                         m_axis_tuser,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  input  logic [PUF_CHANNELS*DATA_WIDTH-1:0] puf_data,
  input  logic [PUF_CHANNELS-1:0]            puf_valid,
  output logic [SEL_WIDTH-1:0]               puf_sela,
  output logic [SEL_WIDTH-1:0]               puf_selb,
  output logic [PUF_CHANNELS-1:0]            puf_w
);

  // When every index value addresses a real channel, the range check must not wrap to zero.
  localparam bit ALL_CH = (DATA_WIDTH < 31) && (PUF_CHANNELS >= (1 << DATA_WIDTH));

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] ch_reg;
  logic [DATA_WIDTH-1:0] run_cnt;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  timeout_hit;
  logic                  accept;
  logic                  ch_ok;
  logic                  tready_q;

  assign accept        = s_axis_tvalid && tready_q;
  assign ch_ok         = ALL_CH || (s_axis_tdata < DATA_WIDTH'(PUF_CHANNELS));
  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = (state == OUT);

  util_axis_puf_chan_mux #(
    .DATA_WIDTH   (DATA_WIDTH),
    .PUF_CHANNELS (PUF_CHANNELS)
  ) u_chan_mux (
    .ch        (ch_reg),
    .puf_data  (puf_data),
    .puf_valid (puf_valid),
    .sel_data  (sel_data),
    .sel_valid (sel_valid)
  );

`ifdef PUF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge aclk or posedge arst) begin
    if (arst)                wait_cnt <= '0;
    else if (state == FIRE)  wait_cnt <= '0;
    else if (state == WAIT)  wait_cnt <= wait_cnt + TW'(1);
  end

  assign timeout_hit = (state == WAIT) && !sel_valid && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state    <= IDLE;
      tready_q <= 1'b0;
    end else begin
      state    <= state_next;
      tready_q <= (state_next == IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (s_axis_tuser == OP_RUN)       state_next = ch_ok ? FIRE : OUT;
          else if (s_axis_tuser == OP_STAT) state_next = OUT;
        end
      end
      FIRE:    state_next = WAIT;
      WAIT:    if (sel_valid || timeout_hit) state_next = OUT;
      OUT:     if (m_axis_tready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The strobe is decoded straight from the state so reset removes it without waiting for a clock.
  always_comb begin
    puf_w = '0;
    if (state == FIRE) begin
      for (int c = 0; c < PUF_CHANNELS; c++) begin
        if (ch_reg == DATA_WIDTH'(c)) puf_w[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      puf_sela     <= '0;
      puf_selb     <= '0;
      ch_reg       <= '0;
      run_cnt      <= '0;
      m_axis_tdata <= '0;
      m_axis_tuser <= ST_OK;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (s_axis_tuser)
              OP_SET_A: puf_sela <= s_axis_tdata[SEL_WIDTH-1:0];
              OP_SET_B: puf_selb <= s_axis_tdata[SEL_WIDTH-1:0];
              OP_RUN: begin
                ch_reg <= s_axis_tdata;
                if (!ch_ok) begin
                  m_axis_tdata <= '0;
                  m_axis_tuser <= ST_BADCH;
                end
              end
              OP_STAT: begin
                m_axis_tdata <= run_cnt;
                m_axis_tuser <= ST_STAT;
              end
              default: ;
            endcase
          end
        end
        WAIT: begin
          if (sel_valid) begin
            m_axis_tdata <= sel_data;
            m_axis_tuser <= ST_OK;
            run_cnt      <= run_cnt + DATA_WIDTH'(1);
          end else if (timeout_hit) begin
            m_axis_tdata <= '0;
            m_axis_tuser <= ST_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
